polyphase_ctrl: RTL
===================

POLYPHASE_CTRL -- requirements
Module: polyphase_ctrl

Interface
REQ-001 Parameter N, default 64, total filter taps; SHALL be a power of two and a multiple of M.
REQ-002 Parameter M, default 4, decimation factor (inputs accepted per output computed).
REQ-003 Parameter MAC_LAT, default 2, cycles from the last mac_en to a valid accumulator result.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous clear of pointers, counters and priming.
REQ-007 in_valid  in  1  upstream sample valid.
REQ-008 in_ready  out  1  controller accepts a sample this cycle.
REQ-009 wr_en  out  1  write the current sample into the sample RAM at wr_addr.
REQ-010 wr_addr  out  log2(N)  sample RAM write address.
REQ-011 rd_addr  out  log2(N)  sample RAM read address.
REQ-012 coef_addr  out  log2(N)  coefficient ROM address.
REQ-013 mac_clr  out  1  load the accumulator with this product instead of adding it.
REQ-014 mac_en  out  1  the MAC consumes rd_addr/coef_addr data this cycle.
REQ-015 mac_last  out  1  final tap of the current output.
REQ-016 out_valid  out  1  accumulator result is valid downstream.
REQ-017 out_ready  in  1  downstream accepts the result.
REQ-018 primed  out  1  at least N samples accepted since reset or flush.

Function
REQ-019 States SHALL be IDLE, MAC, DRAIN and OUT.
REQ-020 in_ready SHALL equal (state==IDLE) and not reset; wr_en SHALL equal in_valid and in_ready, combinationally.
REQ-021 On each accept, wr_ptr SHALL advance by 1 modulo N; wr_addr SHALL equal wr_ptr; phase_cnt SHALL advance modulo M; fill_cnt SHALL saturate at N.
REQ-022 On the accept that wraps phase_cnt to 0, the next state SHALL be MAC if primed (including the case where this accept sets primed), else IDLE.
REQ-023 MAC SHALL last exactly N cycles with tap counter k=0..N-1: mac_en=1, coef_addr=k, rd_addr=(newest-k) mod N, mac_clr=1 only at k=0, mac_last=1 only at k=N-1.
REQ-024 newest SHALL be the address written by the triggering accept.
REQ-025 mac_en SHALL first assert in the cycle after the triggering accept.
REQ-026 Address and MAC outputs SHALL be registered; mac_en, mac_clr and mac_last SHALL be 0 outside MAC.
REQ-027 DRAIN SHALL last MAC_LAT cycles, then go to OUT.
REQ-028 In OUT, out_valid SHALL be 1 and held until out_valid and out_ready are both 1; the next state SHALL then be IDLE.
REQ-029 in_ready SHALL be 0 in MAC, DRAIN and OUT; upstream stalls under backpressure and no sample is dropped.
REQ-030 flush SHALL take priority over all other events in every state.
REQ-031 On flush, next state SHALL be IDLE and wr_ptr, phase_cnt, fill_cnt, k and primed SHALL be 0; any in-flight output SHALL be discarded.
REQ-032 A sample presented in the same cycle as flush SHALL NOT be written.

Reset
REQ-033 While reset is asserted, all state and outputs SHALL be 0 and state SHALL be IDLE; in_ready SHALL be 0 during reset and 1 from the first cycle after release.
REQ-034 Reset mid-MAC or mid-OUT SHALL abort the operation without emitting out_valid.

Structure
REQ-035 A shared package SHALL hold the state enum and the default N, M and MAC_LAT constants.
REQ-036 The address width SHALL be computed as $clog2(N) in that package.
REQ-037 One sub-module, polyphase_tap_cnt (the tap counter and rd_addr generator), is natural; everything else stays in polyphase_ctrl.

Verification
REQ-038 Priming: 64 back-to-back samples -> no mac_en before the 64th accept; then 64 cycles of mac_en with rd_addr 63 down to 0, coef_addr 0..63, and mac_clr and mac_last at the first and last of those cycles respectively; out_valid 3 cycles after mac_last (MAC_LAT=2).
REQ-039 Steady state: 4 further samples -> wr_addr 0..3, then rd_addr sequence 3,2,1,0,63,...,4.
REQ-040 Gapped input: in_valid toggling every other cycle -> MAC starts one cycle after every 4th accept; no extra or missed accepts.
REQ-041 Backpressure: out_ready low for 10 cycles in OUT -> out_valid held, in_ready 0, wr_en 0 throughout; accept on the 11th cycle -> IDLE.
REQ-042 Flush at k=20 with in_valid=1 -> next cycle IDLE, mac_en 0, primed 0, wr_addr 0, no write that cycle.
REQ-043 Asynchronous reset mid-DRAIN -> all outputs 0 immediately; no out_valid after release.

Source files
------------

// File: rtl/polyphase_pkg.sv
// Shared types and default geometry for the polyphase decimator controller.
package polyphase_pkg;

  localparam int unsigned DefN      = 64;
  localparam int unsigned DefM      = 4;
  localparam int unsigned DefMacLat = 2;

  typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} state_e;

  // Address width for an N-entry sample RAM or coefficient ROM.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/polyphase_tap_cnt.sv
// Tap counter: walks k = 0..N-1 and the matching sample address (newest - k) mod N.
module polyphase_tap_cnt
  import polyphase_pkg::*;
#(
  parameter int unsigned N = DefN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 start,
  input  logic [addr_w(N)-1:0] newest,
  output logic [addr_w(N)-1:0] k,
  output logic [addr_w(N)-1:0] rd_addr,
  output logic                 mac_en,
  output logic                 mac_clr,
  output logic                 mac_last
);

  localparam int unsigned AW = addr_w(N);
  localparam logic [AW-1:0] KLast = AW'(N - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k        <= '0;
      rd_addr  <= '0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      mac_last <= 1'b0;
    end else if (flush) begin
      k        <= '0;
      rd_addr  <= '0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      mac_last <= 1'b0;
    end else if (start) begin
      k        <= '0;
      rd_addr  <= newest;
      mac_en   <= 1'b1;
      mac_clr  <= 1'b1;
      mac_last <= (N == 1);
    end else if (mac_en) begin
      mac_clr <= 1'b0;
      if (k == KLast) begin
        k        <= '0;
        mac_en   <= 1'b0;
        mac_last <= 1'b0;
      end else begin
        k        <= k + AW'(1);
        // Address wraps naturally because N is a power of two.
        rd_addr  <= rd_addr - AW'(1);
        mac_last <= (k == KLast - AW'(1));
      end
    end
  end

endmodule

// File: rtl/polyphase_ctrl.sv
// Polyphase decimation controller: accepts M samples per output, then runs an
// N-tap MAC pass, waits out the MAC pipeline, and hands the result downstream.
module polyphase_ctrl
  import polyphase_pkg::*;
#(
  parameter int unsigned N       = DefN,
  parameter int unsigned M       = DefM,
  parameter int unsigned MAC_LAT = DefMacLat
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [addr_w(N)-1:0] wr_addr,
  output logic [addr_w(N)-1:0] rd_addr,
  output logic [addr_w(N)-1:0] coef_addr,
  output logic                 mac_clr,
  output logic                 mac_en,
  output logic                 mac_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 primed
);

  localparam int unsigned AW = addr_w(N);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [PW-1:0] phase_q;
  logic [FW-1:0] fill_q;
  logic [DW-1:0] drain_q;
  logic          phase_wrap, fill_full, primed_next, start;

  assign in_ready = (state_q == StIdle) && !reset;
  // A sample offered alongside flush is dropped, not written.
  assign wr_en    = in_valid && in_ready && !flush;
  assign wr_addr  = wr_ptr_q;
  assign primed   = fill_full;

  assign phase_wrap  = (phase_q == PW'(M - 1));
  assign fill_full   = (fill_q == FW'(N));
  assign primed_next = fill_full || (fill_q == FW'(N - 1));
  assign start       = wr_en && phase_wrap && primed_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      phase_q   <= '0;
      fill_q    <= '0;
      drain_q   <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      phase_q   <= '0;
      fill_q    <= '0;
      drain_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        phase_q  <= phase_wrap ? '0 : phase_q + PW'(1);
        if (!fill_full) fill_q <= fill_q + FW'(1);
      end
      unique case (state_q)
        StIdle: if (start) state_q <= StMac;
        StMac: begin
          if (mac_last) begin
            drain_q <= '0;
            if (MAC_LAT == 0) begin
              state_q   <= StOut;
              out_valid <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (drain_q == DW'(MAC_LAT - 1)) begin
            state_q   <= StOut;
            out_valid <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        StOut: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  polyphase_tap_cnt #(
    .N (N)
  ) u_tap_cnt (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .start    (start),
    .newest   (wr_ptr_q),
    .k        (coef_addr),
    .rd_addr  (rd_addr),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .mac_last (mac_last)
  );

endmodule
